// File: rtl/axi4lite_regfile.sv
// -----------------------------------------------------------------------------
// axi4lite_regfile
//
// Parametrised AXI4-Lite slave register file. Word-aligned addresses select one
// of NUM_REGS registers. Writes honour WSTRB byte lanes. AW and W may arrive in
// the same cycle or in either order with any gap. The register contents are
// also exported flat on reg_out, and wr_pulse flags each committed write.
//
// Optional feature macro: AXIL_REGFILE_SLVERR_EN
//   defined     : out-of-range accesses respond SLVERR (2'b10).
//   not defined : out-of-range writes are dropped and reads return 0, both OKAY.
//
// Parameters
//   ADDR_WIDTH  : AXI byte-address width
//   DATA_WIDTH  : data width (8, 16, 32 or 64)
//   NUM_REGS    : number of registers, 1 .. 2^(ADDR_WIDTH-ADDR_LSB)
//   RESET_VALUE : reset contents of every register
//
// Ports
//   clk, rst            : sole clock (rising edge), synchronous active-high reset
//   s_axi_aw*           : write address channel (awaddr, awvalid, awready)
//   s_axi_w*            : write data channel (wdata, wstrb, wvalid, wready)
//   s_axi_b*            : write response channel (bresp, bvalid, bready)
//   s_axi_ar*           : read address channel (araddr, arvalid, arready)
//   s_axi_r*            : read data channel (rdata, rresp, rvalid, rready)
//   reg_out             : register i on bits [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse            : one-cycle pulse on bit i when a write commits to reg i
// -----------------------------------------------------------------------------
module axi4lite_regfile #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int STRB_W   = DATA_WIDTH / 8;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  aw_held;
  logic                  w_held;
  logic                  bvalid;
  logic                  rvalid;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Byte-offset bits carry no meaning for word-aligned registers.
  generate
    if (ADDR_LSB > 0) begin : g_unused_lsb
      logic unused_addr_lsb;
      assign unused_addr_lsb = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshakes. Ready outputs depend on registered state only.
  // ---------------------------------------------------------------------------
  assign s_axi_awready = !aw_held && !bvalid;
  assign s_axi_wready  = !w_held && !bvalid;
  assign s_axi_arready = !rvalid;

  logic aw_hs, w_hs, ar_hs, commit;
  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  // Commit as soon as both halves are either held or arriving this edge.
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  // Effective write operands: the held copy wins, otherwise the live bus.
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  assign wr_idx  = aw_held ? aw_idx_q : s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data = w_held  ? w_data_q : s_axi_wdata;
  assign wr_strb = w_held  ? w_strb_q : s_axi_wstrb;

  logic [IDX_W-1:0] rd_idx;
  assign rd_idx = s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

  // Decode. An out-of-range index matches no register, so writes drop and
  // reads fall through to zero without any extra range logic.
  logic [NUM_REGS-1:0]   wr_sel;
  logic [DATA_WIDTH-1:0] rd_word;
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    wr_sel  = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && (wr_idx == IDX_W'(i))) wr_sel[i] = 1'b1;
      if (rd_idx == IDX_W'(i))             rd_word   = regs[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Channel control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      bvalid     <= 1'b0;
      rvalid     <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= wr_sel;

      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
        if (bvalid && s_axi_bready) bvalid <= 1'b0;
      end

      if (aw_hs) aw_idx_q <= s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end

      // NOTE: non-blocking assignments mean rd_word is the pre-edge register
      // value, so a read captured on a commit edge returns the old contents.
      if (ar_hs) begin
        rvalid  <= 1'b1;
        rdata_q <= rd_word;
      end else if (s_axi_rready) begin
        rvalid  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register array with byte-lane writes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this array is reset element by element because its reset value
      // is architecturally visible on reg_out; that keeps it out of RAM macros.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Responses
  // ---------------------------------------------------------------------------
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [IDX_W:0] NUM_REGS_W  = (IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  logic       wr_in_range, rd_in_range;
  logic [1:0] bresp_q, rresp_q;
  assign wr_in_range = {1'b0, wr_idx} < NUM_REGS_W;
  assign rd_in_range = {1'b0, rd_idx} < NUM_REGS_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
    end else begin
      if (commit) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs)  rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign s_axi_bresp = bresp_q;
  assign s_axi_rresp = rresp_q;
`else
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
`endif

  assign s_axi_bvalid = bvalid;
  assign s_axi_rvalid = rvalid;
  assign s_axi_rdata  = rdata_q;
  assign wr_pulse     = wr_pulse_q;

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule
